dcache_refill_ctrl: RTL
=======================

# dcache_refill_ctrl

Miss handler for the 8-way, 2-set data cache in the MEM stage. It latches a miss reported by the cache lookup and stalls the pipeline. Read misses fetch the word from backing memory over a valid/ready request and valid response. It then writes the word and tag into a victim way chosen round-robin per set, and pulses done so the cache lookup replays and hits.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, line/word width (one word per line)
- WAYS, 8, ways per set
- SETS, 2, sets; set = blockAddr mod SETS
- TIMEOUT, 255, max cycles in WAIT before abort
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- missValid  in  1  cache lookup missed this cycle
- missAddr  in  ADDR_W  byte address of the missing access
- missIsWrite  in  1  miss is a store
- missWData  in  DATA_W  store data
- stall  out  1  hold pipeline
- memReqValid  out  1  read request to backing memory
- memReqReady  in  1  memory accepts request
- memReqAddr  out  ADDR_W  {blockAddr, 3'b000}
- memRespValid  in  1  response data valid
- memRespData  in  DATA_W  returned word
- fillValid  out  1  one-cycle write strobe into cache arrays
- fillSet  out  log2(SETS)  target set
- fillWay  out  log2(WAYS)  victim way
- fillTag  out  ADDR_W-3  full blockAddr (missAddr[31:3]) stored as tag
- fillData  out  DATA_W  word to install
- doneValid  out  1  one-cycle pulse: miss resolved, replay access
- errFlag  out  1  sticky; set on response timeout

## Operation
- blockAddr = missAddr[31:3]; set = blockAddr[0].
- States: IDLE, REQ, WAIT, FILL, DONE.
- IDLE: on missValid, latch missAddr, missIsWrite and missWData. Read goes to REQ. Write goes directly to FILL with fillData = latched missWData (write-allocate, no fetch; memory is updated by the separate write-through path, never by this block).
- REQ: memReqValid=1, memReqAddr stable. On memReqReady the block moves to WAIT and clears the wait counter.
- WAIT: on memRespValid, capture memRespData and go to FILL. The counter increments each cycle. When the counter reaches TIMEOUT without a response, set errFlag and go to DONE with no fill.
- FILL: fillValid=1 for exactly one cycle with set/way/tag/data. The victim pointer of that set increments and wraps 7->0. Then DONE.
- DONE: doneValid=1 for one cycle. Back to IDLE.
- Victim: one log2(WAYS)-bit round-robin pointer per set. A fill in one set never changes the other set's pointer.
- missValid is ignored in every state except IDLE, including DONE. memRespValid is ignored outside WAIT. memReqReady is ignored outside REQ.
- errFlag is cleared only by rst.

## Timing
- Reset values: state IDLE, every output 0, victim pointers 0, errFlag 0, latched fields 0.
- rst mid-operation: next cycle IDLE with all outputs 0. An outstanding memory response arriving afterward is discarded.
- stall = (IDLE & missValid) | REQ | WAIT | FILL. The stall is combinational in the miss cycle so no instruction advances. It is low in DONE.
- All other outputs are registered from state.
- Read miss, ready immediate, response N cycles after accept: miss at cycle 0. REQ at 1, WAIT at 2, response at 1+N, FILL at 2+N, DONE at 3+N. Minimum miss-to-done is 4 cycles (N=1).
- Write miss: miss at 0, FILL at 1, DONE at 2.
- Back-to-back misses: a new miss is accepted on the cycle after DONE (IDLE).

## Structure
- Shared package dcache_pkg holds:
  - WAYS, SETS, BLOCK_OFF=3, TAG_W=29
  - the state enum typedef, reused by the cache and this block
- One sub-module, victim_rr: the per-set pointer array. Inputs are clk, rst, advance and set. The output is the current way for the given set.

## Test plan
- Read miss at addr 0x00000700 (blockAddr 0xE0, set 0) with memReqReady=1 and response 0xDEADBEEF 3 cycles after accept. Expect memReqAddr=0x700, then fillValid with set 0, way 0, tag 0xE0, data 0xDEADBEEF, then doneValid. stall is high exactly from cycle 0 to the cycle before DONE.
- Write miss at 0x00000708 (set 1) with data 0x12345678. Expect no memReqValid, FILL at cycle 1 with set 1, way 0, data 0x12345678, and DONE at cycle 2.
- Nine read misses to set 0, each followed by one to set 1. Expect set-0 ways 0..7 then 0 (wrap), and set-1 way incrementing independently from 0.
- Hold memReqReady=0 for 5 cycles. Expect memReqValid and memReqAddr stable throughout. A spurious memRespValid during REQ is ignored.
- Response never arrives. Expect DONE after TIMEOUT WAIT cycles, errFlag=1 and sticky, no fillValid, and the victim pointer unchanged.
- Assert rst in WAIT, then assert memRespValid in the following IDLE cycle. Expect all outputs 0, no fill, errFlag 0, and pointers 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: geometry constants and the refill state type.
package dcache_pkg;

   localparam int WAYS      = 8;
   localparam int SETS      = 2;
   localparam int BLOCK_OFF = 3;
   localparam int TAG_W     = 29;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_FILL = 3'd3,
      S_DONE = 3'd4
   } refill_state_e;

endpackage

// File: rtl/dcache_refill_ctrl_victim_rr.sv
// Per-set round-robin victim pointers; a fill only advances the pointer of its own set.
module victim_rr
   import dcache_pkg::*;
#(
   parameter int NWAYS = WAYS,
   parameter int NSETS = SETS,
   localparam int WW   = $clog2(NWAYS),
   localparam int SW   = (NSETS > 1) ? $clog2(NSETS) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          advance_i,
   input  logic [SW-1:0] set_i,
   output logic [WW-1:0] way_o
);

   logic [WW-1:0] ptr_q [NSETS];

   // Power-of-two way count, so the natural overflow gives the 7->0 wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NSETS; i++) ptr_q[i] <= '0;
      end else if (advance_i) begin
         ptr_q[set_i] <= ptr_q[set_i] + WW'(1);
      end
   end

   assign way_o = ptr_q[set_i];

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: latches a miss, fetches on reads, fills a round-robin victim, pulses done.
// Handshake: memReqValid holds with a stable address until memReqReady; memRespValid counts only in WAIT.
module dcache_refill_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int WAYS     = dcache_pkg::WAYS,
   parameter int SETS     = dcache_pkg::SETS,
   parameter int TIMEOUT  = 255,
   localparam int SET_W   = (SETS > 1) ? $clog2(SETS) : 1,
   localparam int WAY_W   = $clog2(WAYS),
   localparam int BLK_W   = ADDR_W - dcache_pkg::BLOCK_OFF
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       missValid_i,
   input  logic [ADDR_W-1:0]          missAddr_i,
   input  logic                       missIsWrite_i,
   input  logic [DATA_W-1:0]          missWData_i,
   output logic                       stall_o,
   output logic                       memReqValid_o,
   input  logic                       memReqReady_i,
   output logic [ADDR_W-1:0]          memReqAddr_o,
   input  logic                       memRespValid_i,
   input  logic [DATA_W-1:0]          memRespData_i,
   output logic                       fillValid_o,
   output logic [SET_W-1:0]           fillSet_o,
   output logic [WAY_W-1:0]           fillWay_o,
   output logic [BLK_W-1:0]           fillTag_o,
   output logic [DATA_W-1:0]          fillData_o,
   output logic                       doneValid_o,
   output logic                       errFlag_o,
   output dcache_pkg::refill_state_e  dbgState_o
);
   import dcache_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   refill_state_e     state_q, state_d;
   logic [BLK_W-1:0]  blk_q, blk_d;
   logic              is_write_q, is_write_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [SET_W-1:0]  set_w;
   logic [WAY_W-1:0]  way_w;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^missAddr_i[BLOCK_OFF-1:0] ^ is_write_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         blk_q      <= '0;
         is_write_q <= 1'b0;
         data_q     <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         is_write_q <= is_write_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      is_write_d = is_write_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      stall_o    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (missValid_i) begin
               stall_o    = 1'b1;
               blk_d      = missAddr_i[ADDR_W-1:BLOCK_OFF];
               is_write_d = missIsWrite_i;
               data_d     = missWData_i;
               // Write-allocate: store data is installed directly, no fetch.
               state_d    = missIsWrite_i ? S_FILL : S_REQ;
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (memReqReady_i) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (memRespValid_i) begin
               data_d  = memRespData_i;
               state_d = S_FILL;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FILL: begin
            stall_o = 1'b1;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign set_w = blk_q[SET_W-1:0];

   victim_rr #(
      .NWAYS (WAYS),
      .NSETS (SETS)
   ) u_victim (
      .clk       (clk),
      .rst       (rst),
      .advance_i (state_q == S_FILL),
      .set_i     (set_w),
      .way_o     (way_w)
   );

   // Data outputs are zeroed outside their strobe so idle/reset presents all zeros.
   assign memReqValid_o = (state_q == S_REQ);
   assign memReqAddr_o  = memReqValid_o ? {blk_q, {BLOCK_OFF{1'b0}}} : '0;
   assign fillValid_o   = (state_q == S_FILL);
   assign fillSet_o     = fillValid_o ? set_w : '0;
   assign fillWay_o     = fillValid_o ? way_w : '0;
   assign fillTag_o     = fillValid_o ? blk_q : '0;
   assign fillData_o    = fillValid_o ? data_q : '0;
   assign doneValid_o   = (state_q == S_DONE);
   assign errFlag_o     = err_q;
   assign dbgState_o    = state_q;

endmodule
